ysyx_23060025_if_id_fifo: RTL and testbench

- Buffered fetch-to-decode boundary between the IFU and the IDU.
- Accepts {pc, inst} pairs from the IFU over a valid/ready handshake and stores them in a small FIFO.
- Presents the head entry to the decoder with the instruction pre-split into the key fields that the decoder's key-lookup multiplexers consume: opcode, funct3, funct7, rd, rs1, rs2.
- Supports a pipeline flush for branch/jump redirect.

---
 rtl/ysyx_23060025_if_id_fifo.sv | 100 ++++++++++
 tb/tb_ysyx_23060025_if_id_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_if_id_fifo.sv
// IF/ID boundary FIFO: buffers {pc, inst} pairs from the fetch unit and presents
// the head entry to the decoder with the RV32 key fields already split out.
module ysyx_23060025_if_id_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    input  logic [INST_WIDTH-1:0]   in_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic [INST_WIDTH-1:0]   out_inst,
    output logic [6:0]              out_opcode,
    output logic [4:0]              out_rd,
    output logic [2:0]              out_funct3,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [6:0]              out_funct7,
    output logic [$clog2(DEPTH):0]  out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Full/empty come from the occupancy count, so pointers can wrap freely.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only observable once count covers it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr_q]   <= in_pc;
            inst_mem[wr_ptr_q] <= in_inst;
        end
    end

    assign out_pc     = out_valid ? pc_mem[rd_ptr_q]   : '0;
    assign out_inst   = out_valid ? inst_mem[rd_ptr_q] : '0;
    assign out_opcode = out_inst[6:0];
    assign out_rd     = out_inst[11:7];
    assign out_funct3 = out_inst[14:12];
    assign out_rs1    = out_inst[19:15];
    assign out_rs2    = out_inst[24:20];
    assign out_funct7 = out_inst[31:25];
    assign out_count  = count_q;

endmodule

// File: tb/tb_ysyx_23060025_if_id_fifo.sv
// Bench for the IF/ID FIFO: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ysyx_23060025_if_id_fifo;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [1:0]  out_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] mq[$];   // {pc, inst}, head at index 0

    ysyx_23060025_if_id_fifo #(
        .ADDR_WIDTH(32),
        .INST_WIDTH(32),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_opcode(out_opcode),
        .out_rd    (out_rd),
        .out_funct3(out_funct3),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .out_funct7(out_funct7),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference: a plain queue with capacity DEPTH; flush and reset empty it.
    bit m_can_push;
    bit m_can_pop;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            m_can_push = (mq.size() < DEPTH);
            m_can_pop  = (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (out_ready && m_can_pop) void'(mq.pop_front());
                if (in_valid && m_can_push) mq.push_back({in_pc, in_inst});
            end
        end
    end

    task automatic compare_model();
        logic [63:0] h;
        logic [31:0] hi;
        h  = (mq.size() > 0) ? mq[0] : 64'd0;
        hi = h[31:0];
        check("m_in_ready",  {63'd0, in_ready},  {63'd0, mq.size() != DEPTH});
        check("m_out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
        check("m_out_count", {62'd0, out_count}, 64'(mq.size()));
        check("m_out_pc",    {32'd0, out_pc},    {32'd0, h[63:32]});
        check("m_out_inst",  {32'd0, out_inst},  {32'd0, hi});
        check("m_fields",
              {25'd0, out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode},
              {25'd0, hi[31:25], hi[24:20], hi[19:15], hi[14:12], hi[11:7], hi[6:0]});
    endtask

    always @(negedge clk) compare_model();

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        in_pc   = '0;
        in_inst = '0;
        #12 rst = 1'b0;

        // Reset then idle
        nxt();
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_count", {62'd0, out_count}, 64'd0);
        check("rst_out_inst",  {32'd0, out_inst},  64'd0);
        check("rst_opcode",    {57'd0, out_opcode}, 64'd0);

        // Single push, then three stall cycles
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0050_0093;
        nxt();
        in_valid = 1'b0;
        check("p1_valid",  {63'd0, out_valid},  64'd1);
        check("p1_count",  {62'd0, out_count},  64'd1);
        check("p1_opcode", {57'd0, out_opcode}, 64'h13);
        check("p1_rd",     {59'd0, out_rd},     64'd1);
        check("p1_funct3", {61'd0, out_funct3}, 64'd0);
        check("p1_rs1",    {59'd0, out_rs1},    64'd0);
        check("p1_funct7", {57'd0, out_funct7}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("stall_pc",   {32'd0, out_pc},   64'h8000_0000);
            check("stall_inst", {32'd0, out_inst}, 64'h0050_0093);
        end
        out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;
        check("p1_drained", {63'd0, out_valid}, 64'd0);

        // Fill to full, rejected third push, then one pop
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0050_0093;
        nxt();
        in_pc = 32'h8000_0004; in_inst = 32'h4020_8133;
        nxt();
        check("full_count", {62'd0, out_count}, 64'd2);
        check("full_ready", {63'd0, in_ready},  64'd0);
        in_pc = 32'h8000_0008; in_inst = 32'h0000_0013;
        nxt();
        check("rej_count", {62'd0, out_count}, 64'd2);
        check("rej_head",  {32'd0, out_pc},    64'h8000_0000);
        in_valid = 1'b0; out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;
        check("pop_pc",     {32'd0, out_pc},     64'h8000_0004);
        check("pop_funct7", {57'd0, out_funct7}, 64'h20);
        check("pop_rs2",    {59'd0, out_rs2},    64'd2);
        check("pop_rs1",    {59'd0, out_rs1},    64'd1);
        check("pop_rd",     {59'd0, out_rd},     64'd2);
        check("pop_opcode", {57'd0, out_opcode}, 64'h33);
        check("pop_ready",  {63'd0, in_ready},   64'd1);
        out_ready = 1'b1;
        nxt();
        out_ready = 1'b0;

        // Streaming: one in, one out per cycle
        in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h0000_0013;
        for (int k = 0; k < 10; k++) begin
            in_pc = 32'h8000_0000 + 32'(4 * k);
            nxt();
            check("stream_count", {62'd0, out_count}, 64'd1);
            check("stream_pc",    {32'd0, out_pc},    64'(32'h8000_0000 + 32'(4 * k)));
        end
        in_valid = 1'b0;
        nxt();
        out_ready = 1'b0;
        check("stream_empty", {63'd0, out_valid}, 64'd0);

        // Flush wins over a concurrent push and pop
        in_valid = 1'b1; in_pc = 32'h8000_0020; in_inst = 32'h0010_0113;
        nxt();
        flush = 1'b1; in_pc = 32'h9000_0000; out_ready = 1'b1;
        nxt();
        idle();
        check("flush_count", {62'd0, out_count}, 64'd0);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        nxt();
        check("flush_gone", {32'd0, out_pc}, 64'd0);

        // Asynchronous reset with two entries buffered
        in_valid = 1'b1; in_pc = 32'h8000_0030;
        nxt();
        in_pc = 32'h8000_0034;
        nxt();
        in_valid = 1'b0;
        check("pre_rst_count", {62'd0, out_count}, 64'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_ready", {63'd0, in_ready},  64'd1);
        check("arst_count", {62'd0, out_count}, 64'd0);
        #1 rst = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0010; in_inst = 32'h0000_0013;
        nxt();
        in_valid = 1'b0;
        check("post_rst_pc", {32'd0, out_pc}, 64'h8000_0010);
        out_ready = 1'b1;
        nxt();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (c % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_pc     = $urandom();
            in_inst   = $urandom();
            nxt();
        end
        idle();
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
